ifm_pingpong_responder: RTL and testbench

- Double-buffered inter-layer IFM memory between a producer layer (e.g. pooling S1) and the ConvA2 consumer.
- Responder end of ConvA2's previous-layer read interface: serves start_from_previous, ifm_sel/address reads and end_to_previous.
- Producer fills one bank while the consumer reads the other. Three parallel read lanes feed the three conv units.

---
 rtl/ifm_pingpong_responder_pkg.sv | 28 ++
 rtl/ifm_bank_ram.sv | 39 +++
 rtl/ifm_pingpong_responder.sv | 135 +++++++++++++
 tb/tb_ifm_pingpong_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifm_pingpong_responder_pkg.sv
// Shared geometry, bank-state encoding and lane mapping for the
// ping-pong IFM responder.
package ifm_pingpong_responder_pkg;

    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned IFM_SIZE         = 5;
    localparam int unsigned IFM_DEPTH        = 16;
    localparam int unsigned NUMBER_OF_UNITS  = 3;
    localparam int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE);
    localparam int unsigned CH_BITS          = $clog2(IFM_DEPTH);
    localparam int unsigned SEL_BITS         = $clog2(IFM_DEPTH / NUMBER_OF_UNITS + 1);

    localparam logic [ADDRESS_SIZE_IFM-1:0] MAP_WORDS = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE);
    localparam logic [CH_BITS:0]            DEPTH_LIM = (CH_BITS + 1)'(IFM_DEPTH);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FULL    = 2'd1,
        BANK_READING = 2'd2
    } bank_state_t;

    // One extra bit so a group index past the last map is detectable.
    function automatic logic [CH_BITS:0] lane_map(input logic [SEL_BITS-1:0] sel,
                                                  input int unsigned         u);
        return (CH_BITS + 1)'(32'(sel) * NUMBER_OF_UNITS + u);
    endfunction

endpackage

// File: rtl/ifm_bank_ram.sv
// One IFM bank: single write port, NUM_PORTS registered read ports that
// return zero for lanes flagged invalid and hold while re is low.
module ifm_bank_ram
    import ifm_pingpong_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ifm_pingpong_responder_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned NUM_PORTS  = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  we,
    input  logic [ADDR_WIDTH-1:0]                 waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic                                  re,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  raddr,
    input  logic [NUM_PORTS-1:0]                  rvalid,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rdata[p] <= rvalid[p] ? mem[raddr[p]] : '0;
            end
        end
    end

endmodule

// File: rtl/ifm_pingpong_responder.sv
// Double-buffered IFM store: producer fills one bank while ConvA2 reads
// the other over three parallel lanes.
module ifm_pingpong_responder
    import ifm_pingpong_responder_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        prod_write_enable,
    input  logic [CH_BITS-1:0]          prod_channel,
    input  logic [ADDRESS_SIZE_IFM-1:0] prod_address,
    input  logic [DATA_WIDTH-1:0]       prod_data,
    input  logic                        prod_done,
    output logic                        prod_ready,
    output logic                        start_to_consumer,
    input  logic                        cons_enable_read,
    input  logic [ADDRESS_SIZE_IFM-1:0] cons_address,
    input  logic [SEL_BITS-1:0]         cons_sel,
    input  logic                        cons_end,
    output logic [DATA_WIDTH-1:0]       data_out1,
    output logic [DATA_WIDTH-1:0]       data_out2,
    output logic [DATA_WIDTH-1:0]       data_out3,
    output logic                        overrun_error
);

    localparam int unsigned RAM_AW = CH_BITS + ADDRESS_SIZE_IFM;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        rd_sel_q;
    logic        prod_ready_q, start_q, overrun_q;

    logic        handoff;
    logic        wr_in_range, wr_accept, wr_blocked;
    logic [1:0]  ram_we, ram_re;

    logic [CH_BITS:0]                           lane_m   [NUMBER_OF_UNITS];
    logic [NUMBER_OF_UNITS-1:0][RAM_AW-1:0]     rd_addr;
    logic [NUMBER_OF_UNITS-1:0]                 rd_valid;
    logic [NUMBER_OF_UNITS-1:0][DATA_WIDTH-1:0] rdata    [2];

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_sel_q     <= 1'b0;
            prod_ready_q <= 1'b0;
            start_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            prod_ready_q <= (bank_q[wr_bank_q] == BANK_EMPTY);
            start_q      <= handoff;
            if (wr_blocked) begin
                overrun_q <= 1'b1;
            end
            if (cons_enable_read) begin
                rd_sel_q <= rd_bank_q;
            end
        end
    end

    // Next state: done, end and hand-off always touch different banks.
    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (prod_done && bank_q[wr_bank_q] == BANK_EMPTY) begin
            bank_d[wr_bank_q] = BANK_FULL;
            wr_bank_d         = ~wr_bank_q;
        end
        if (cons_end && bank_q[rd_bank_q] == BANK_READING) begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end
        if (handoff) begin
            bank_d[rd_bank_q] = BANK_READING;
        end
    end

    always_comb begin
        handoff     = (bank_q[rd_bank_q] == BANK_FULL) &&
                      (bank_q[0] != BANK_READING) && (bank_q[1] != BANK_READING);
        wr_in_range = ((CH_BITS + 1)'(prod_channel) < DEPTH_LIM) && (prod_address < MAP_WORDS);
        wr_blocked  = prod_write_enable && (bank_q[wr_bank_q] != BANK_EMPTY);
        wr_accept   = prod_write_enable && (bank_q[wr_bank_q] == BANK_EMPTY) && wr_in_range;
        ram_we            = '0;
        ram_we[wr_bank_q] = wr_accept;
        ram_re            = '0;
        ram_re[rd_bank_q] = cons_enable_read;
    end

    always_comb begin
        rd_addr  = '0;
        rd_valid = '0;
        for (int unsigned u = 0; u < NUMBER_OF_UNITS; u++) begin
            lane_m[u]   = lane_map(cons_sel, u);
            rd_addr[u]  = {lane_m[u][CH_BITS-1:0], cons_address};
            rd_valid[u] = (lane_m[u] < DEPTH_LIM) && (cons_address < MAP_WORDS);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ifm_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (RAM_AW),
            .NUM_PORTS  (NUMBER_OF_UNITS)
        ) u_ram (
            .clk    (clk),
            .reset  (reset),
            .we     (ram_we[b]),
            .waddr  ({prod_channel, prod_address}),
            .wdata  (prod_data),
            .re     (ram_re[b]),
            .raddr  (rd_addr),
            .rvalid (rd_valid),
            .rdata  (rdata[b])
        );
    end

    // Lane mux follows the bank that served the most recent read.
    assign data_out1         = rd_sel_q ? rdata[1][0] : rdata[0][0];
    assign data_out2         = rd_sel_q ? rdata[1][1] : rdata[0][1];
    assign data_out3         = rd_sel_q ? rdata[1][2] : rdata[0][2];
    assign prod_ready        = prod_ready_q;
    assign start_to_consumer = start_q;
    assign overrun_error     = overrun_q;

endmodule

// File: tb/tb_ifm_pingpong_responder.sv
// Bench for ifm_pingpong_responder: directed scenarios plus randomized
// producer/consumer traffic, checked against a per-cycle behavioural model.
module tb_ifm_pingpong_responder;
    import ifm_pingpong_responder_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset = 1'b0;
    logic                        prod_write_enable = 1'b0;
    logic [CH_BITS-1:0]          prod_channel = '0;
    logic [ADDRESS_SIZE_IFM-1:0] prod_address = '0;
    logic [DATA_WIDTH-1:0]       prod_data = '0;
    logic                        prod_done = 1'b0;
    logic                        prod_ready;
    logic                        start_to_consumer;
    logic                        cons_enable_read = 1'b0;
    logic [ADDRESS_SIZE_IFM-1:0] cons_address = '0;
    logic [SEL_BITS-1:0]         cons_sel = '0;
    logic                        cons_end = 1'b0;
    logic [DATA_WIDTH-1:0]       data_out1, data_out2, data_out3;
    logic                        overrun_error;

    ifm_pingpong_responder dut (
        .clk               (clk),
        .reset             (reset),
        .prod_write_enable (prod_write_enable),
        .prod_channel      (prod_channel),
        .prod_address      (prod_address),
        .prod_data         (prod_data),
        .prod_done         (prod_done),
        .prod_ready        (prod_ready),
        .start_to_consumer (start_to_consumer),
        .cons_enable_read  (cons_enable_read),
        .cons_address      (cons_address),
        .cons_sel          (cons_sel),
        .cons_end          (cons_end),
        .data_out1         (data_out1),
        .data_out2         (data_out2),
        .data_out3         (data_out3),
        .overrun_error     (overrun_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: a bank either holds data or not, and may be in use
    // by the consumer; outputs are what the rules say after each edge.
    int unsigned m_mem [2][IFM_DEPTH][IFM_SIZE*IFM_SIZE];
    bit          has_data [2];
    bit          in_use   [2];
    bit          m_wr, m_rd, m_ok = 1'b0;
    bit          m_reading_any;
    bit          e_ready, e_start, e_ovr, nxt_ready, go;
    logic [31:0] e_d [3];
    int unsigned lm;

    always @(posedge clk) begin
        if (!reset) begin
            has_data = '{0, 0};
            in_use   = '{0, 0};
            m_wr = 0; m_rd = 0;
            e_ready = 0; e_start = 0; e_ovr = 0;
            e_d = '{0, 0, 0};
            m_ok = 1'b1;
        end else begin
            nxt_ready = !has_data[m_wr];
            go = has_data[m_rd] && !in_use[m_rd] && !in_use[0] && !in_use[1];
            if (cons_enable_read) begin
                for (int u = 0; u < 3; u++) begin
                    lm = int'(cons_sel) * 3 + u;
                    e_d[u] = (lm < IFM_DEPTH && cons_address < IFM_SIZE*IFM_SIZE) ?
                             m_mem[m_rd][lm][cons_address] : 0;
                end
            end
            if (prod_write_enable) begin
                if (has_data[m_wr]) e_ovr = 1;
                else if (prod_channel < IFM_DEPTH && prod_address < IFM_SIZE*IFM_SIZE)
                    m_mem[m_wr][prod_channel][prod_address] = prod_data;
            end
            if (go) in_use[m_rd] = 1;
            if (prod_done && !has_data[m_wr]) begin
                has_data[m_wr] = 1;
                m_wr = !m_wr;
            end
            if (cons_end && in_use[m_rd] && !go) begin
                has_data[m_rd] = 0;
                in_use[m_rd] = 0;
                m_rd = !m_rd;
            end
            e_ready = nxt_ready;
            e_start = go;
        end
        m_reading_any = in_use[0] || in_use[1];
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("cyc_prod_ready", prod_ready, e_ready);
            check("cyc_start", start_to_consumer, e_start);
            check("cyc_overrun", overrun_error, e_ovr);
            check("cyc_data_out1", data_out1, e_d[0]);
            check("cyc_data_out2", data_out2, e_d[1]);
            check("cyc_data_out3", data_out3, e_d[2]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int unsigned base);
        for (int unsigned c = 0; c < IFM_DEPTH; c++) begin
            for (int unsigned a = 0; a < IFM_SIZE*IFM_SIZE; a++) begin
                prod_write_enable = 1'b1;
                prod_channel = CH_BITS'(c);
                prod_address = ADDRESS_SIZE_IFM'(a);
                prod_data    = base + c * 100 + a;
                step();
            end
        end
        prod_write_enable = 1'b0;
    endtask

    task automatic pulse_done();
        prod_done = 1'b1;
        step();
        prod_done = 1'b0;
    endtask

    task automatic count_start(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            step();
            if (start_to_consumer === 1'b1) cnt++;
        end
    endtask

    task automatic rd(input int unsigned sel, input int unsigned addr);
        cons_enable_read = 1'b1;
        cons_sel = SEL_BITS'(sel);
        cons_address = ADDRESS_SIZE_IFM'(addr);
        step();
        cons_enable_read = 1'b0;
    endtask

    task automatic check_outs(input string name, input int unsigned a, input int unsigned b,
                              input int unsigned c);
        check({name, "_d1"}, data_out1, a);
        check({name, "_d2"}, data_out2, b);
        check({name, "_d3"}, data_out3, c);
    endtask

    int n;
    int pidx, cool, nreads;

    initial begin
        repeat (3) step();
        check("rst_ready", prod_ready, 0);
        check("rst_start", start_to_consumer, 0);
        check("rst_overrun", overrun_error, 0);
        check_outs("rst", 0, 0, 0);
        reset = 1'b1;
        step();
        check("ready_after_rst", prod_ready, 1);

        // Bank0 fill and hand-off.
        fill(0);
        pulse_done();
        check("start_not_early", start_to_consumer, 0);
        count_start(4, n);
        check("start_pulses_bank0", n, 1);
        check("ready_bank1_empty", prod_ready, 1);

        rd(1, 7);
        check_outs("sel1_a7", 307, 407, 507);
        step();
        check("hold_d1", data_out1, 307);
        rd(5, 0);
        check_outs("sel5_a0", 1500, 0, 0);
        rd(0, 25);
        check_outs("addr_oob", 0, 0, 0);

        // Bank1 filled behind the reading bank0.
        fill(5000);
        pulse_done();
        step();
        check("ready_both_busy", prod_ready, 0);
        count_start(3, n);
        check("no_start_while_reading", n, 0);
        prod_write_enable = 1'b1; prod_channel = '0; prod_address = '0; prod_data = 32'hDEAD;
        step();
        prod_write_enable = 1'b0;
        check("overrun_set", overrun_error, 1);

        cons_end = 1'b1;
        step();
        cons_end = 1'b0;
        check("no_start_at_end", start_to_consumer, 0);
        step();
        check("start_after_end", start_to_consumer, 1);
        check("ready_after_free", prod_ready, 1);
        rd(0, 0);
        check_outs("bank1_read", 5000, 5100, 5200);

        // prod_done and cons_end together.
        fill(9000);
        prod_done = 1'b1; cons_end = 1'b1;
        step();
        prod_done = 1'b0; cons_end = 1'b0;
        check("same_cyc_no_start", start_to_consumer, 0);
        step();
        check("same_cyc_start", start_to_consumer, 1);
        check("same_cyc_ready", prod_ready, 1);
        count_start(3, n);
        check("same_cyc_single_start", n, 0);
        rd(1, 24);
        check_outs("bank0_again", 9324, 9424, 9524);

        // Reset while bank0 is being read.
        reset = 1'b0;
        step();
        check("midrst_ready", prod_ready, 0);
        check("midrst_overrun", overrun_error, 0);
        check_outs("midrst", 0, 0, 0);
        reset = 1'b1;
        step();
        check("midrst_ready_rel", prod_ready, 1);
        fill(200);
        pulse_done();
        count_start(4, n);
        check("midrst_start", n, 1);
        rd(4, 10);
        check_outs("midrst_read", 1410, 1510, 1610);

        // Randomized traffic, checked by the per-cycle model.
        pidx = 0; cool = 0; nreads = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            prod_write_enable = 1'b0;
            prod_done = 1'b0;
            cons_enable_read = 1'b0;
            cons_end = 1'b0;
            if (cool > 0) begin
                cool--;
            end else if (prod_ready && pidx < IFM_DEPTH*IFM_SIZE*IFM_SIZE) begin
                if ($urandom_range(5) == 0) begin
                    prod_write_enable = 1'b1;
                    prod_channel = CH_BITS'($urandom);
                    prod_address = ADDRESS_SIZE_IFM'(25 + $urandom_range(6));
                    prod_data = $urandom;
                end else if ($urandom_range(3) != 0) begin
                    prod_write_enable = 1'b1;
                    prod_channel = CH_BITS'(pidx / 25);
                    prod_address = ADDRESS_SIZE_IFM'(pidx % 25);
                    prod_data = $urandom;
                    pidx++;
                end
            end else if (prod_ready) begin
                prod_done = 1'b1;
                pidx = 0;
                cool = 2;
            end
            if (m_reading_any) begin
                if (nreads > 3 && $urandom_range(15) == 0) begin
                    cons_end = 1'b1;
                    nreads = 0;
                end else if ($urandom_range(1) == 1) begin
                    cons_enable_read = 1'b1;
                    cons_sel = SEL_BITS'($urandom);
                    cons_address = ADDRESS_SIZE_IFM'($urandom);
                    nreads++;
                end
            end
            step();
        end
        prod_write_enable = 1'b0;
        prod_done = 1'b0;
        cons_enable_read = 1'b0;
        cons_end = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
